// File: rtl/test_stream_pkg.sv
// Shared types and default widths for the stream test path (source and sink).
package test_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 32;
  localparam int DEFAULT_COUNT_WIDTH = 32;
  localparam int GAP_WIDTH           = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/test_stream_gap_timer.sv
// Down-counter that times the idle gap inserted between throttled beats.
module test_stream_gap_timer
  import test_stream_pkg::*;
#(
  parameter int WIDTH = GAP_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expire
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  // Expire on the last gap cycle so the FSM is back in SEND right after it.
  assign expire = (count == WIDTH'(1));

endmodule

// File: rtl/test_stream_source.sv
// AXI4-Stream packet generator: incrementing tdata, tlast on the final beat, beat/stall counters.
// Defining TEST_STREAM_SOURCE_THROTTLE_EN adds gap_cycles and a GAP state between beats.
module test_stream_source
  import test_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] length,
  input  logic [DATA_WIDTH-1:0]  start_value,
`ifdef TEST_STREAM_SOURCE_THROTTLE_EN
  input  logic [GAP_WIDTH-1:0]   gap_cycles,
`endif
  output logic                   idle,
  output logic                   axis_tvalid,
  output logic [DATA_WIDTH-1:0]  axis_tdata,
  input  logic                   axis_tready,
  output logic                   axis_tlast,
  output logic [COUNT_WIDTH-1:0] beat_count,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  state_t                 state;
  logic [COUNT_WIDTH-1:0] remaining;

`ifdef TEST_STREAM_SOURCE_THROTTLE_EN
  logic [GAP_WIDTH-1:0] gap_len;
  logic                 gap_load;
  logic                 gap_expire;

  assign gap_load = (state == ST_SEND) && axis_tready &&
                    (remaining != '0) && (gap_len != '0);

  test_stream_gap_timer #(
    .WIDTH(GAP_WIDTH)
  ) u_gap_timer (
    .clk       (clk),
    .resetn    (resetn),
    .load      (gap_load),
    .load_value(gap_len),
    .expire    (gap_expire)
  );
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      remaining   <= '0;
      idle        <= 1'b1;
      axis_tvalid <= 1'b0;
      axis_tlast  <= 1'b0;
      axis_tdata  <= '0;
      beat_count  <= '0;
      stall_count <= '0;
`ifdef TEST_STREAM_SOURCE_THROTTLE_EN
      gap_len     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // A zero-length start still clears the counters so the sink can be re-armed.
          if (start) begin
            beat_count  <= '0;
            stall_count <= '0;
            if (length != '0) begin
              state       <= ST_SEND;
              remaining   <= length - COUNT_WIDTH'(1);
              axis_tdata  <= start_value;
              axis_tlast  <= (length == COUNT_WIDTH'(1));
              axis_tvalid <= 1'b1;
              idle        <= 1'b0;
`ifdef TEST_STREAM_SOURCE_THROTTLE_EN
              gap_len     <= gap_cycles;
`endif
            end
          end
        end

        ST_SEND: begin
          if (axis_tready) begin
            beat_count <= beat_count + COUNT_WIDTH'(1);
            if (remaining == '0) begin
              state       <= ST_IDLE;
              idle        <= 1'b1;
              axis_tvalid <= 1'b0;
              axis_tlast  <= 1'b0;
            end else begin
              remaining  <= remaining - COUNT_WIDTH'(1);
              axis_tdata <= axis_tdata + DATA_WIDTH'(1);
              axis_tlast <= (remaining == COUNT_WIDTH'(1));
`ifdef TEST_STREAM_SOURCE_THROTTLE_EN
              if (gap_len != '0) begin
                state       <= ST_GAP;
                axis_tvalid <= 1'b0;
              end
`endif
            end
          end else begin
            stall_count <= stall_count + COUNT_WIDTH'(1);
          end
        end

`ifdef TEST_STREAM_SOURCE_THROTTLE_EN
        ST_GAP: begin
          if (gap_expire) begin
            state       <= ST_SEND;
            axis_tvalid <= 1'b1;
          end
        end
`endif

        default: begin
          state       <= ST_IDLE;
          idle        <= 1'b1;
          axis_tvalid <= 1'b0;
          axis_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule
